// File: rtl/usr_frame_rx.sv
// usr_frame_rx: frames the usr serial stream (start/data/parity/stop) into words on a valid/ready port
module usr_frame_rx #(
    parameter int DATA_W     = 4,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_in,
    input  logic              bit_en,
    input  logic              lsb_first,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    localparam int CW = DATA_W > 1 ? $clog2(DATA_W) : 1;
    state_t            state, nxt;
    logic [CW-1:0]     cnt, idx;
    logic [DATA_W-1:0] sh;
    logic              lsb, pend, last, stop_ev, good, load;
    assign last    = cnt == CW'(DATA_W - 1);
    assign idx     = lsb ? cnt : CW'(DATA_W - 1) - cnt;
    assign stop_ev = bit_en & (state == STOP);
    assign good    = stop_ev & bit_in;
    // a good word may land in the holding register while it is being drained
    assign load    = good & (~data_valid | data_ready);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end
    always_comb begin
        nxt = state;
        if (bit_en) begin
            case (state)
                IDLE:    nxt = bit_in ? IDLE : DATA;
                DATA:    nxt = last ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
                PARITY:  nxt = STOP;
                default: nxt = IDLE;
            endcase
        end
    end
    always_comb begin
        busy = state != IDLE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            sh         <= '0;
            lsb        <= 1'b0;
            pend       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= stop_ev & ~bit_in;
            overrun    <= good & data_valid & ~data_ready;
            data_valid <= load | (data_valid & ~data_ready);
            if (bit_en && state == IDLE && !bit_in) begin
                lsb  <= lsb_first;
                cnt  <= '0;
                pend <= 1'b0;
            end
            if (bit_en && state == DATA) begin
                sh[idx] <= bit_in;
                cnt     <= cnt + 1'b1;
            end
            if (bit_en && state == PARITY) pend <= ^sh ^ bit_in ^ 1'(PARITY_ODD);
            if (load) begin
                data_out   <= sh;
                parity_err <= pend;
            end else if (data_valid && data_ready) begin
                parity_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_usr_frame_rx.sv
// tb_usr_frame_rx: directed checks of usr_frame_rx, even-parity DUT plus an odd-parity twin on the same stimulus
module tb_usr_frame_rx;
    logic       clk = 1'b0, reset = 1'b0;
    logic       bit_in = 1'b1, bit_en = 1'b0, lsb_first = 1'b1, data_ready = 1'b0;
    logic [3:0] data_out, o_data;
    logic       data_valid, parity_err, frame_err, overrun, busy;
    logic       o_valid, o_perr, o_ferr, o_ovr, o_busy;
    int         checks = 0, failures = 0;
    always #5 clk = ~clk;
    usr_frame_rx #(.DATA_W(4), .PARITY_EN(1), .PARITY_ODD(0)) dut (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_en(bit_en), .lsb_first(lsb_first),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy));
    usr_frame_rx #(.DATA_W(4), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_en(bit_en), .lsb_first(lsb_first),
        .data_out(o_data), .data_valid(o_valid), .data_ready(data_ready),
        .parity_err(o_perr), .frame_err(o_ferr), .overrun(o_ovr), .busy(o_busy));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // idle for gap clocks, then strobe one bit; data_ready only rides along with the strobe
    task automatic send_bit(input logic b, input int gap, input logic rdy);
        repeat (gap) tick();
        bit_in = b;
        bit_en = 1'b1;
        data_ready = rdy;
        tick();
        bit_en = 1'b0;
        data_ready = 1'b0;
        bit_in = 1'b1;
    endtask
    // bits[6] is sent first: start, 4 data, parity, stop
    task automatic frame(input logic [6:0] bits, input int gapmax, input logic rdy_on_stop);
        for (int i = 6; i >= 0; i--)
            send_bit(bits[i], gapmax > 0 ? int'($urandom_range(gapmax, 0)) : 0, i == 0 ? rdy_on_stop : 1'b0);
    endtask
    task automatic accept();
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
    endtask
    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
    initial begin
        repeat (3) tick();
        chk("rst_valid", data_valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        tick();
        frame(7'b0101001, 0, 1'b0);
        chk("t1_data", data_out, 4'b0101);
        chk("t1_valid", data_valid, 1);
        chk("t1_perr", parity_err, 0);
        chk("t1_odd_perr", o_perr, 1);
        chk("t1_busy", busy, 0);
        send_bit(1'b0, 0, 1'b0);
        send_bit(1'b1, 0, 1'b0);
        send_bit(1'b1, 0, 1'b0);
        chk("mid_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_data", data_out, 0);
        chk("arst_valid", data_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_perr", o_perr, 0);
        tick();
        reset = 1'b1;
        tick();
        frame(7'b0101001, 0, 1'b0);
        chk("t1b_data", data_out, 4'b0101);
        chk("t1b_valid", data_valid, 1);
        accept();
        chk("acc_valid", data_valid, 0);
        chk("acc_data", data_out, 4'b0101);
        chk("acc_odd_perr", o_perr, 0);
        lsb_first = 1'b0;
        send_bit(1'b0, 0, 1'b0);
        send_bit(1'b1, 0, 1'b0);
        lsb_first = 1'b1;
        send_bit(1'b0, 0, 1'b0);
        send_bit(1'b1, 0, 1'b0);
        send_bit(1'b0, 0, 1'b0);
        send_bit(1'b0, 0, 1'b0);
        send_bit(1'b1, 0, 1'b0);
        chk("t2_data", data_out, 4'b1010);
        chk("t2_perr", parity_err, 0);
        accept();
        frame(7'b0111001, 0, 1'b0);
        chk("t3_data", data_out, 4'b0111);
        chk("t3_perr", parity_err, 1);
        chk("t3_odd_perr", o_perr, 0);
        chk("t3_valid", data_valid, 1);
        accept();
        chk("t3_perr_clr", parity_err, 0);
        frame(7'b0101000, 0, 1'b0);
        chk("t4_ferr", frame_err, 1);
        chk("t4_valid", data_valid, 0);
        chk("t4_data", data_out, 4'b0111);
        tick();
        chk("t4_ferr_pulse", frame_err, 0);
        frame(7'b0100011, 0, 1'b0);
        chk("t5_ovr0", overrun, 0);
        chk("t5_data_a", data_out, 4'b0001);
        frame(7'b0010011, 0, 1'b0);
        chk("t5_ovr", overrun, 1);
        chk("t5_hold", data_out, 4'b0001);
        chk("t5_valid", data_valid, 1);
        tick();
        chk("t5_ovr_pulse", overrun, 0);
        frame(7'b0010011, 0, 1'b1);
        chk("t5_load", data_out, 4'b0010);
        chk("t5_valid2", data_valid, 1);
        chk("t5_no_ovr", overrun, 0);
        accept();
        chk("t5_drain", data_valid, 0);
        frame(7'b0101001, 5, 1'b0);
        chk("t6_data_a", data_out, 4'b0101);
        chk("t6_perr_a", parity_err, 0);
        accept();
        frame(7'b0111001, 5, 1'b0);
        chk("t6_data_b", data_out, 4'b0111);
        chk("t6_perr_b", parity_err, 1);
        chk("t6_valid", data_valid, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
